// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the shared CPU memory bus: captures one-cycle request
// pulses, issues one downstream transaction at a time and routes the response back.
module mem_bus_arbiter #(
    parameter int RR_MODE        = 1,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_p0_DV,
    input  logic        i_p0_write_notread,
    input  logic [2:0]  i_p0_bhw,
    input  logic [31:0] i_p0_address,
    input  logic [31:0] i_p0_data,
    input  logic        i_p1_DV,
    input  logic        i_p1_write_notread,
    input  logic [2:0]  i_p1_bhw,
    input  logic [31:0] i_p1_address,
    input  logic [31:0] i_p1_data,
    output logic        o_p0_rsp_DV,
    output logic [31:0] o_p0_rsp_data,
    output logic        o_p0_rsp_err,
    output logic        o_p0_overrun,
    output logic        o_p1_rsp_DV,
    output logic [31:0] o_p1_rsp_data,
    output logic        o_p1_rsp_err,
    output logic        o_p1_overrun,
    output logic        o_bus_DV,
    output logic        o_write_notread,
    output logic [2:0]  o_bhw,
    output logic [31:0] o_bus_address,
    output logic [31:0] o_bus_data,
    input  logic        i_input_bus_DV,
    input  logic [31:0] i_input_bus_data,
    output logic        o_grant,
    output logic        o_busy
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int TO_LAST_I = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CNT_W-1:0] TO_LAST = TO_LAST_I[CNT_W-1:0];
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    state_t           state;
    logic [1:0]       pending;
    logic             last_grant;
    logic [CNT_W-1:0] cnt;

    logic [1:0]        req_dv;
    logic [1:0]        req_wnr;
    logic [1:0][2:0]   req_bhw;
    logic [1:0][31:0]  req_addr;
    logic [1:0][31:0]  req_data;

    logic [1:0]        slot_wnr;
    logic [1:0][2:0]   slot_bhw;
    logic [1:0][31:0]  slot_addr;
    logic [1:0][31:0]  slot_data;

    logic [1:0]        rsp_dv;
    logic [1:0][31:0]  rsp_data;
    logic [1:0]        rsp_err;
    logic [1:0]        overrun;

    logic              timed_out;
    logic              wait_done;
    logic [1:0]        clear_slot;
    logic [1:0]        capture;
    logic              win;

    // Tie goes to the port not served last in round-robin, else port 0 always.
    function automatic logic pick_winner(input logic [1:0] pend, input logic last);
        if (pend == 2'b11) begin
            return (RR_MODE != 0) ? ~last : 1'b0;
        end
        return pend[1] & ~pend[0];
    endfunction

    assign req_dv   = {i_p1_DV, i_p0_DV};
    assign req_wnr  = {i_p1_write_notread, i_p0_write_notread};
    assign req_bhw  = {i_p1_bhw, i_p0_bhw};
    assign req_addr = {i_p1_address, i_p0_address};
    assign req_data = {i_p1_data, i_p0_data};

    assign timed_out  = TO_EN && (cnt == TO_LAST);
    assign wait_done  = (state == WAIT) && (i_input_bus_DV || timed_out);
    assign clear_slot = wait_done ? (o_grant ? 2'b10 : 2'b01) : 2'b00;
    // A new pulse in the cycle its slot is being released is accepted.
    assign capture    = req_dv & (~pending | clear_slot);
    assign win        = pick_winner(pending, last_grant);

    always_ff @(posedge i_clk) begin
        for (int n = 0; n < 2; n++) begin
            if (capture[n]) begin
                slot_wnr[n]  <= req_wnr[n];
                slot_bhw[n]  <= req_bhw[n];
                slot_addr[n] <= req_addr[n];
                slot_data[n] <= req_data[n];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            pending         <= 2'b00;
            last_grant      <= 1'b1;
            cnt             <= '0;
            o_grant         <= 1'b0;
            o_busy          <= 1'b0;
            o_bus_DV        <= 1'b0;
            o_write_notread <= 1'b0;
            o_bhw           <= 3'b000;
            o_bus_address   <= 32'h0;
            o_bus_data      <= 32'h0;
            rsp_dv          <= 2'b00;
            rsp_data        <= '0;
            rsp_err         <= 2'b00;
            overrun         <= 2'b00;
        end else begin
            o_bus_DV <= 1'b0;
            rsp_dv   <= 2'b00;
            overrun  <= req_dv & pending & ~clear_slot;
            pending  <= capture | (pending & ~clear_slot);

            case (state)
                IDLE: begin
                    if (|pending) begin
                        o_grant         <= win;
                        o_write_notread <= slot_wnr[win];
                        o_bhw           <= slot_bhw[win];
                        o_bus_address   <= slot_addr[win];
                        o_bus_data      <= slot_data[win];
                        o_bus_DV        <= 1'b1;
                        o_busy          <= 1'b1;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (wait_done) begin
                        rsp_dv[o_grant]   <= 1'b1;
                        rsp_data[o_grant] <= i_input_bus_DV ? i_input_bus_data : TIMEOUT_DATA;
                        rsp_err[o_grant]  <= ~i_input_bus_DV;
                        last_grant        <= o_grant;
                        o_busy            <= 1'b0;
                        state             <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_p0_rsp_DV   = rsp_dv[0];
    assign o_p0_rsp_data = rsp_data[0];
    assign o_p0_rsp_err  = rsp_err[0];
    assign o_p0_overrun  = overrun[0];
    assign o_p1_rsp_DV   = rsp_dv[1];
    assign o_p1_rsp_data = rsp_data[1];
    assign o_p1_rsp_err  = rsp_err[1];
    assign o_p1_overrun  = overrun[1];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: instance 0 round-robin, instance 1 fixed
// priority, both with an 8-cycle response timeout.
module tb_mem_bus_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    logic [1:0][1:0]       p_dv;
    logic [1:0][1:0]       p_wnr;
    logic [1:0][1:0][2:0]  p_bhw;
    logic [1:0][1:0][31:0] p_addr;
    logic [1:0][1:0][31:0] p_data;
    logic [1:0]            in_dv;
    logic [1:0][31:0]      in_data;

    logic [1:0][1:0]       rsp_dv;
    logic [1:0][1:0][31:0] rsp_data;
    logic [1:0][1:0]       rsp_err;
    logic [1:0][1:0]       ovr;
    logic [1:0]            bus_dv;
    logic [1:0]            bus_wnr;
    logic [1:0][2:0]       bus_bhw;
    logic [1:0][31:0]      bus_addr;
    logic [1:0][31:0]      bus_data;
    logic [1:0]            grant;
    logic [1:0]            busy;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_bus_arbiter #(.RR_MODE(g == 0 ? 1 : 0), .TIMEOUT_CYCLES(8)) u_dut (
            .i_clk(clk), .i_rst(rst),
            .i_p0_DV(p_dv[g][0]), .i_p0_write_notread(p_wnr[g][0]), .i_p0_bhw(p_bhw[g][0]),
            .i_p0_address(p_addr[g][0]), .i_p0_data(p_data[g][0]),
            .i_p1_DV(p_dv[g][1]), .i_p1_write_notread(p_wnr[g][1]), .i_p1_bhw(p_bhw[g][1]),
            .i_p1_address(p_addr[g][1]), .i_p1_data(p_data[g][1]),
            .o_p0_rsp_DV(rsp_dv[g][0]), .o_p0_rsp_data(rsp_data[g][0]),
            .o_p0_rsp_err(rsp_err[g][0]), .o_p0_overrun(ovr[g][0]),
            .o_p1_rsp_DV(rsp_dv[g][1]), .o_p1_rsp_data(rsp_data[g][1]),
            .o_p1_rsp_err(rsp_err[g][1]), .o_p1_overrun(ovr[g][1]),
            .o_bus_DV(bus_dv[g]), .o_write_notread(bus_wnr[g]), .o_bhw(bus_bhw[g]),
            .o_bus_address(bus_addr[g]), .o_bus_data(bus_data[g]),
            .i_input_bus_DV(in_dv[g]), .i_input_bus_data(in_data[g]),
            .o_grant(grant[g]), .o_busy(busy[g])
        );
    end

    typedef struct {
        int          cyc;
        logic        grant;
        logic        wnr;
        logic [2:0]  bhw;
        logic [31:0] addr;
        logic [31:0] data;
    } bus_exp_t;

    typedef struct {
        int          cyc;
        logic [31:0] data;
        logic        err;
    } rsp_exp_t;

    bus_exp_t bus_q [2][$];
    rsp_exp_t rsp_q [4][$];
    int       ovr_q [4][$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every output event must match the head of its queue, cycle included.
    bus_exp_t be;
    rsp_exp_t re;
    int       oc;
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (bus_dv[i]) begin
                chk($sformatf("bus%0d_expected", i), bus_q[i].size() != 0, 1);
                if (bus_q[i].size() != 0) begin
                    be = bus_q[i].pop_front();
                    chk($sformatf("bus%0d_cycle", i), cyc, be.cyc);
                    chk($sformatf("bus%0d_addr", i), bus_addr[i], be.addr);
                    chk($sformatf("bus%0d_fields", i),
                        {grant[i], bus_wnr[i], bus_bhw[i], bus_data[i]},
                        {be.grant, be.wnr, be.bhw, be.data});
                    chk($sformatf("bus%0d_busy", i), busy[i], 1);
                end
            end
            for (int p = 0; p < 2; p++) begin
                if (rsp_dv[i][p]) begin
                    chk($sformatf("rsp%0d_p%0d_expected", i, p), rsp_q[i*2+p].size() != 0, 1);
                    if (rsp_q[i*2+p].size() != 0) begin
                        re = rsp_q[i*2+p].pop_front();
                        chk($sformatf("rsp%0d_p%0d_cycle", i, p), cyc, re.cyc);
                        chk($sformatf("rsp%0d_p%0d_err_data", i, p),
                            {rsp_err[i][p], rsp_data[i][p]}, {re.err, re.data});
                    end
                end
                if (ovr[i][p]) begin
                    chk($sformatf("ovr%0d_p%0d_expected", i, p), ovr_q[i*2+p].size() != 0, 1);
                    if (ovr_q[i*2+p].size() != 0) begin
                        oc = ovr_q[i*2+p].pop_front();
                        chk($sformatf("ovr%0d_p%0d_cycle", i, p), cyc, oc);
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        p_dv  = '0;
        in_dv = '0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic req(input int i, input int p, input logic wnr, input logic [2:0] bhw,
                       input logic [31:0] addr, input logic [31:0] data);
        p_dv[i][p]   = 1'b1;
        p_wnr[i][p]  = wnr;
        p_bhw[i][p]  = bhw;
        p_addr[i][p] = addr;
        p_data[i][p] = data;
    endtask

    task automatic downstream(input int i, input logic [31:0] d);
        in_dv[i]   = 1'b1;
        in_data[i] = d;
    endtask

    task automatic exp_bus(input int i, input int c, input logic g, input logic wnr,
                           input logic [2:0] bhw, input logic [31:0] addr, input logic [31:0] data);
        bus_exp_t e;
        e.cyc = c; e.grant = g; e.wnr = wnr; e.bhw = bhw; e.addr = addr; e.data = data;
        bus_q[i].push_back(e);
    endtask

    task automatic exp_rsp(input int i, input int p, input int c, input logic [31:0] d, input logic err);
        rsp_exp_t e;
        e.cyc = c; e.data = d; e.err = err;
        rsp_q[i*2+p].push_back(e);
    endtask

    task automatic check_idle(input int i, input string tag);
        chk($sformatf("%s_ctl%0d", tag, i),
            {rsp_dv[i], rsp_err[i], ovr[i], bus_dv[i], bus_wnr[i], bus_bhw[i], grant[i], busy[i]}, '0);
        chk($sformatf("%s_rspdata%0d", tag, i), rsp_data[i], '0);
        chk($sformatf("%s_busfields%0d", tag, i), {bus_addr[i], bus_data[i]}, '0);
    endtask

    int t;

    initial begin
        rst = 1'b1;
        p_dv = '0; p_wnr = '0; p_bhw = '0; p_addr = '0; p_data = '0;
        in_dv = '0; in_data = '0;
        repeat (3) tick();
        check_idle(0, "rst");
        check_idle(1, "rst");
        rst = 1'b0;
        tick();
        check_idle(0, "post_rst");
        check_idle(1, "post_rst");

        // Same-cycle pair straight after reset: port 0 wins the first tie.
        t = cyc;
        req(0, 0, 1'b0, 3'b100, 32'h0000_1000, 32'h0);
        req(0, 1, 1'b1, 3'b001, 32'h0000_2001, 32'h0000_005A);
        exp_bus(0, t + 2, 1'b0, 1'b0, 3'b100, 32'h0000_1000, 32'h0);
        exp_rsp(0, 0, t + 4, 32'hA0A0_0001, 1'b0);
        exp_bus(0, t + 5, 1'b1, 1'b1, 3'b001, 32'h0000_2001, 32'h0000_005A);
        exp_rsp(0, 1, t + 7, 32'h1111_1111, 1'b0);
        wait_until(t + 3); downstream(0, 32'hA0A0_0001);
        wait_until(t + 6); downstream(0, 32'h1111_1111);
        wait_until(t + 8);

        // Lone port-0 load, downstream answers 3 cycles after issue.
        t = cyc;
        req(0, 0, 1'b0, 3'b100, 32'h0000_0100, 32'h0);
        exp_bus(0, t + 2, 1'b0, 1'b0, 3'b100, 32'h0000_0100, 32'h0);
        exp_rsp(0, 0, t + 6, 32'hCAFE_F00D, 1'b0);
        wait_until(t + 5); downstream(0, 32'hCAFE_F00D);
        wait_until(t + 9);
        chk("p0_rsp_data_hold", rsp_data[0][0], 32'hCAFE_F00D);

        // Port 0 was served last, so the next tie goes to port 1.
        t = cyc;
        req(0, 0, 1'b0, 3'b010, 32'h0000_1002, 32'h0);
        req(0, 1, 1'b1, 3'b100, 32'h0000_3000, 32'h1234_5678);
        exp_bus(0, t + 2, 1'b1, 1'b1, 3'b100, 32'h0000_3000, 32'h1234_5678);
        exp_rsp(0, 1, t + 4, 32'h0, 1'b0);
        exp_bus(0, t + 5, 1'b0, 1'b0, 3'b010, 32'h0000_1002, 32'h0);
        exp_rsp(0, 0, t + 7, 32'h0000_BEEF, 1'b0);
        wait_until(t + 3); downstream(0, 32'h0);
        wait_until(t + 6); downstream(0, 32'h0000_BEEF);
        wait_until(t + 8);

        // Timeout: 8 WAIT cycles with no answer, then a late answer in IDLE.
        t = cyc;
        req(0, 1, 1'b0, 3'b100, 32'h0000_4000, 32'h0);
        exp_bus(0, t + 2, 1'b1, 1'b0, 3'b100, 32'h0000_4000, 32'h0);
        exp_rsp(0, 1, t + 11, 32'hDEAD_BEEF, 1'b1);
        wait_until(t + 13); downstream(0, 32'h5555_5555);
        wait_until(t + 15);
        chk("p1_rsp_data_after_late_dv", rsp_data[0][1], 32'hDEAD_BEEF);

        // Overrun while queued behind port 1, DV during ISSUE, re-capture on release.
        t = cyc;
        req(0, 1, 1'b0, 3'b100, 32'h0000_6000, 32'h0);
        exp_bus(0, t + 2, 1'b1, 1'b0, 3'b100, 32'h0000_6000, 32'h0);
        exp_rsp(0, 1, t + 5, 32'h0000_0060, 1'b0);
        wait_until(t + 1); req(0, 0, 1'b0, 3'b100, 32'h0000_0200, 32'h0);
        wait_until(t + 3); req(0, 0, 1'b1, 3'b100, 32'h0000_0300, 32'h0000_0077);
        ovr_q[0].push_back(t + 4);
        wait_until(t + 4); downstream(0, 32'h0000_0060);
        exp_bus(0, t + 6, 1'b0, 1'b0, 3'b100, 32'h0000_0200, 32'h0);
        exp_rsp(0, 0, t + 9, 32'h0BAD_F00D, 1'b0);
        wait_until(t + 6); downstream(0, 32'h9999_9999);
        wait_until(t + 8); downstream(0, 32'h0BAD_F00D);
        req(0, 0, 1'b0, 3'b001, 32'h0000_0205, 32'h0);
        exp_bus(0, t + 10, 1'b0, 1'b0, 3'b001, 32'h0000_0205, 32'h0);
        exp_rsp(0, 0, t + 12, 32'h0000_00AB, 1'b0);
        wait_until(t + 11); downstream(0, 32'h0000_00AB);
        wait_until(t + 13);

        // Reset in WAIT: everything clears, the queued port-0 request is lost.
        t = cyc;
        req(0, 1, 1'b0, 3'b100, 32'h0000_7000, 32'h0);
        exp_bus(0, t + 2, 1'b1, 1'b0, 3'b100, 32'h0000_7000, 32'h0);
        wait_until(t + 3); req(0, 0, 1'b0, 3'b100, 32'h0000_7100, 32'h0);
        wait_until(t + 4); rst = 1'b1;
        wait_until(t + 5); rst = 1'b0;
        check_idle(0, "mid_rst");
        wait_until(t + 6); downstream(0, 32'h4444_4444);
        wait_until(t + 12);
        chk("busy_after_mid_rst", busy[0], 1'b0);

        // Fixed priority: port 0 re-requests as each response lands and keeps winning.
        t = cyc;
        req(1, 0, 1'b0, 3'b100, 32'h0000_8000, 32'h0);
        req(1, 1, 1'b0, 3'b100, 32'h0000_9000, 32'h0);
        exp_bus(1, t + 2, 1'b0, 1'b0, 3'b100, 32'h0000_8000, 32'h0);
        exp_rsp(1, 0, t + 4, 32'h0000_0080, 1'b0);
        exp_bus(1, t + 5, 1'b0, 1'b0, 3'b100, 32'h0000_8004, 32'h0);
        exp_rsp(1, 0, t + 7, 32'h0000_0084, 1'b0);
        exp_bus(1, t + 8, 1'b0, 1'b0, 3'b100, 32'h0000_8008, 32'h0);
        exp_rsp(1, 0, t + 10, 32'h0000_0088, 1'b0);
        exp_bus(1, t + 11, 1'b1, 1'b0, 3'b100, 32'h0000_9000, 32'h0);
        exp_rsp(1, 1, t + 13, 32'h0000_0090, 1'b0);
        wait_until(t + 3);
        downstream(1, 32'h0000_0080);
        req(1, 0, 1'b0, 3'b100, 32'h0000_8004, 32'h0);
        wait_until(t + 6);
        downstream(1, 32'h0000_0084);
        req(1, 0, 1'b0, 3'b100, 32'h0000_8008, 32'h0);
        wait_until(t + 9);  downstream(1, 32'h0000_0088);
        wait_until(t + 12); downstream(1, 32'h0000_0090);
        wait_until(t + 15);

        for (int i = 0; i < 2; i++) chk($sformatf("bus%0d_left", i), bus_q[i].size(), 0);
        for (int q = 0; q < 4; q++) begin
            chk($sformatf("rsp_q%0d_left", q), rsp_q[q].size(), 0);
            chk($sformatf("ovr_q%0d_left", q), ovr_q[q].size(), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
